// File: rtl/crc32_png_if.sv
// rtl/crc32_png_if.sv - beat input and CRC result bundle for crc32_png
//   start_i  begin new CRC (register reloads INIT)
//   val_i    dat_i/lst_i valid this cycle
//   dat_i    data beat, DW bits, LSB byte first
//   lst_i    beat closes the message
//   done_o   one-cycle pulse: CRC of the last beat is on dat_o
//   val_o    one-cycle pulse: dat_o updated for the previous beat
//   dat_o    finalized CRC, held between updates
interface crc32_png_if #(
  parameter int DW = 8
) ();
  logic          start_i;
  logic          val_i;
  logic [DW-1:0] dat_i;
  logic          lst_i;
  logic          done_o;
  logic          val_o;
  logic [31:0]   dat_o;

  modport master (
    output start_i, val_i, dat_i, lst_i,
    input  done_o, val_o, dat_o
  );

  modport slave (
    input  start_i, val_i, dat_i, lst_i,
    output done_o, val_o, dat_o
  );
endinterface

// File: rtl/crc32_png.sv
// rtl/crc32_png.sv - streaming reflected CRC-32 (zlib/PNG) with auto-rearm after last beat
//   clk   rising-edge clock
//   rstn  synchronous reset, active high (rstn=1 resets)
//   bus   crc32_png_if slave: start_i/val_i/dat_i/lst_i in, done_o/val_o/dat_o out
module crc32_png #(
  parameter int          DW     = 8,
  parameter logic [31:0] POLY   = 32'hEDB88320,
  parameter logic [31:0] INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT = 32'hFFFFFFFF
) (
  input  logic          clk,
  input  logic          rstn,
  crc32_png_if.slave    bus
);

  localparam int NB = DW / 8;

  logic [31:0] crc_q, crc_d;
  logic [31:0] dat_q, dat_d;
  logic        val_q, val_d;
  logic        done_q, done_d;

  logic [31:0] base;
  logic [31:0] next_crc;

  // Whole beat folded in one cycle, byte 0 (lowest lane) first.
  function automatic logic [31:0] crc_beat(input logic [31:0] c_in,
                                           input logic [DW-1:0] d);
    logic [31:0] c;
    c = c_in;
    for (int b = 0; b < NB; b++) begin
      c = c ^ {24'h000000, d[8*b +: 8]};
      for (int k = 0; k < 8; k++) begin
        c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
      end
    end
    return c;
  endfunction

  // start_i overrides the running value in the same cycle so a beat
  // arriving with start_i is folded onto INIT, not onto stale state.
  assign base     = bus.start_i ? INIT : crc_q;
  assign next_crc = crc_beat(base, bus.dat_i);

  always_comb begin
    crc_d  = crc_q;
    dat_d  = dat_q;
    val_d  = 1'b0;
    done_d = 1'b0;
    if (bus.val_i) begin
      dat_d  = next_crc ^ XOROUT;
      val_d  = 1'b1;
      done_d = bus.lst_i;
      // Re-arm after the last beat so the next message needs no start_i.
      crc_d  = bus.lst_i ? INIT : next_crc;
    end else if (bus.start_i) begin
      crc_d  = INIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      crc_q  <= INIT;
      dat_q  <= 32'h0;
      val_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      crc_q  <= crc_d;
      dat_q  <= dat_d;
      val_q  <= val_d;
      done_q <= done_d;
    end
  end

  assign bus.dat_o  = dat_q;
  assign bus.val_o  = val_q;
  assign bus.done_o = done_q;

endmodule

// File: tb/tb_crc32_png.sv
// tb/tb_crc32_png.sv - scoreboard bench for crc32_png
module tb_crc32_png;

  localparam logic [31:0] INIT = 32'hFFFFFFFF;
  localparam logic [31:0] POLY = 32'hEDB88320;

  typedef struct packed {
    logic [31:0] crc;
    logic        done;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rst_d;

  always #5 clk = ~clk;

  crc32_png_if #(.DW(8)) bus ();

  crc32_png #(.DW(8)) dut (
    .clk  (clk),
    .rstn (rst),
    .bus  (bus)
  );

  exp_t        sbq[$];
  logic [31:0] done_log[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_dat = 32'h0;
  logic [31:0] mreg = INIT;
  exp_t        e;

  // Bit-serial reference: feedback bit = lsb of register xor data bit.
  function automatic logic [31:0] sw_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = c >> 1;
      if (fb) c = c ^ POLY;
    end
    return c;
  endfunction

  function automatic logic [31:0] crc_msg(input logic [7:0] q[$]);
    logic [31:0] c;
    c = INIT;
    foreach (q[i]) c = sw_byte(c, q[i]);
    return ~c;
  endfunction

  always @(posedge clk) rst_d <= rst;

  always @(negedge clk) begin
    if (rst_d === 1'b1) begin
      checks += 3;
      assert (bus.dat_o === 32'h0) else begin errors++; $error("FAIL reset_dat got=%h exp=%h", bus.dat_o, 32'h0); end
      assert (bus.val_o === 1'b0) else begin errors++; $error("FAIL reset_val got=%b exp=0", bus.val_o); end
      assert (bus.done_o === 1'b0) else begin errors++; $error("FAIL reset_done got=%b exp=0", bus.done_o); end
      last_dat = 32'h0;
    end else if (bus.val_o === 1'b1) begin
      checks++;
      assert (sbq.size() != 0) else begin errors++; $error("FAIL spurious_val got=1 exp=0"); end
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        checks += 2;
        assert (bus.dat_o === e.crc) else begin errors++; $error("FAIL beat_crc got=%h exp=%h", bus.dat_o, e.crc); end
        assert (bus.done_o === e.done) else begin errors++; $error("FAIL beat_done got=%b exp=%b", bus.done_o, e.done); end
      end
      last_dat = bus.dat_o;
      if (bus.done_o === 1'b1) done_log.push_back(bus.dat_o);
    end else begin
      checks += 2;
      assert (bus.done_o === 1'b0) else begin errors++; $error("FAIL idle_done got=%b exp=0", bus.done_o); end
      assert (bus.dat_o === last_dat) else begin errors++; $error("FAIL hold_dat got=%h exp=%h", bus.dat_o, last_dat); end
    end
  end

  task automatic drive(input logic s, input logic v, input logic l, input logic [7:0] d);
    logic [31:0] base;
    logic [31:0] nxt;
    exp_t        x;
    bus.start_i = s;
    bus.val_i   = v;
    bus.lst_i   = l;
    bus.dat_i   = d;
    if (v) begin
      base   = s ? INIT : mreg;
      nxt    = sw_byte(base, d);
      x.crc  = ~nxt;
      x.done = l;
      sbq.push_back(x);
      mreg   = l ? INIT : nxt;
    end else if (s) begin
      mreg = INIT;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, logic'($urandom_range(0, 1)), 8'($urandom));
  endtask

  task automatic send(input logic [7:0] q[$], input logic with_start, input int max_gap);
    foreach (q[i]) begin
      drive(with_start && (i == 0), 1'b1, i == q.size() - 1, q[i]);
      if (max_gap > 0 && i != q.size() - 1) repeat ($urandom_range(0, max_gap)) idle();
    end
  endtask

  task automatic expect_done(input string tag, input int n, input logic [31:0] last_exp);
    @(negedge clk);
    #1;
    checks += 2;
    assert (done_log.size() == n) else begin errors++; $error("FAIL %s_done_count got=%0d exp=%0d", tag, done_log.size(), n); end
    assert (done_log.size() != 0 && done_log[done_log.size() - 1] === last_exp)
      else begin errors++; $error("FAIL %s_crc got=%h exp=%h", tag,
                                  (done_log.size() != 0) ? done_log[done_log.size() - 1] : 32'hx, last_exp); end
    done_log.delete();
  endtask

  initial begin
    logic [7:0] chk[$];
    logic [7:0] iend[$];
    logic [7:0] rnd[$];
    logic [7:0] one[$];
    int         len;

    chk  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    iend = '{8'h49, 8'h45, 8'h4E, 8'h44};
    one  = '{8'h04};

    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.val_i   = 1'b0;
    bus.lst_i   = 1'b0;
    bus.dat_i   = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mreg = INIT;
    idle();

    // single-byte message
    send(one, 1'b1, 0);
    expect_done("single", 1, 32'hD56F2B94);

    // check string back-to-back
    send(chk, 1'b1, 0);
    expect_done("check", 1, 32'hCBF43926);

    // IEND with idle gaps
    send(iend, 1'b1, 3);
    expect_done("iend_gaps", 1, 32'hAE426082);

    // abandoned message then restart
    drive(1'b0, 1'b1, 1'b0, 8'hA5);
    drive(1'b0, 1'b1, 1'b0, 8'h5A);
    drive(1'b0, 1'b1, 1'b0, 8'hC3);
    send(iend, 1'b1, 0);
    expect_done("restart", 1, 32'hAE426082);

    // back-to-back messages relying on auto-rearm
    send(chk, 1'b0, 0);
    send(iend, 1'b0, 0);
    expect_done("rearm", 2, 32'hAE426082);

    // reset mid-message
    drive(1'b1, 1'b1, 1'b0, 8'h77);
    drive(1'b0, 1'b1, 1'b0, 8'h88);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    mreg = INIT;
    idle();
    send(chk, 1'b0, 0);
    expect_done("after_reset", 1, 32'hCBF43926);

    // random lengths against the whole-message reference
    for (int m = 0; m < 10; m++) begin
      rnd.delete();
      len = $urandom_range(1, 64);
      for (int i = 0; i < len; i++) rnd.push_back(8'($urandom));
      send(rnd, logic'(m % 2), (m % 3 == 0) ? 2 : 0);
      expect_done("random", 1, crc_msg(rnd));
    end

    repeat (3) idle();
    checks++;
    assert (sbq.size() == 0) else begin errors++; $error("FAIL sb_drain got=%0d exp=0", sbq.size()); end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
